instr_fetch: RTL and testbench



---
 rtl/instr_fetch_pkg.sv | 28 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_branch_lut.sv | 17 +
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state type, default widths and the branch-target table.
package fetch_pkg;

  localparam int PC_W_DEFAULT      = 10;
  localparam int INSTR_W_DEFAULT   = 9;
  localparam int LUT_IDX_W_DEFAULT = 5;
  localparam int OPCODE_W          = 4;
  localparam int LUT_DEPTH         = 2 ** LUT_IDX_W_DEFAULT;

  localparam logic [INSTR_W_DEFAULT-1:0] HALT_WORD_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Branch targets indexed by the low instruction bits. Entry 3 is a mid-program
  // target and entry 31 points at the last address so a branch can reach the wrap.
  localparam logic [PC_W_DEFAULT-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'd0,   10'd16,  10'd32,  10'd40,  10'd64,  10'd80,  10'd96,  10'd112,
    10'd128, 10'd144, 10'd160, 10'd176, 10'd192, 10'd208, 10'd224, 10'd240,
    10'd256, 10'd272, 10'd288, 10'd304, 10'd320, 10'd336, 10'd352, 10'd368,
    10'd384, 10'd400, 10'd416, 10'd432, 10'd448, 10'd464, 10'd480, 10'd1023
  };

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory and Control-decoder signals of the fetch unit.
// master is the fetch sequencer, slave is the memory/decoder side.
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
);

  logic [PC_W-1:0]     instr_addr;
  logic [INSTR_W-1:0]  instr_rdata;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic                fetch_valid;
  logic                branch;

  modport master (
    output instr_addr, instr, opcode, fetch_valid,
    input  instr_rdata, branch
  );

  modport slave (
    input  instr_addr, instr, opcode, fetch_valid,
    output instr_rdata, branch
  );

endinterface

// File: rtl/instr_fetch_branch_lut.sv
// branch_lut: combinational lookup of a branch target from the instruction index.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      target
);

  // Table read, zero-extended or trimmed to the program counter width
  always_comb begin
    target = PC_W'(BRANCH_LUT[idx]);
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and single-cycle instruction fetch sequencer.
// Optional macro INSTR_COUNT_EN adds a saturating 16-bit executed-instruction counter.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEFAULT,
  parameter int                 INSTR_W   = INSTR_W_DEFAULT,
  parameter int                 LUT_IDX_W = LUT_IDX_W_DEFAULT,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  instr_fetch_if.master     bus,
  output logic [PC_W-1:0]   pc,
  output logic              done
`ifdef INSTR_COUNT_EN
  ,output logic [15:0]      instr_count
`endif
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] branch_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .idx    (bus.instr_rdata[LUT_IDX_W-1:0]),
    .target (branch_target)
  );

  // State and program counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next pc; start beats stall, stall beats halt, halt beats branch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (start) begin
          pc_d = '0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (bus.instr_rdata == HALT_WORD) begin
          state_d = HALT;
        end else if (bus.branch) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Fetch outputs: memory read data passes straight through to the decoder
  always_comb begin
    bus.instr_addr  = pc_q;
    bus.instr       = bus.instr_rdata;
    bus.opcode      = bus.instr_rdata[INSTR_W-1 -: OPCODE_W];
    bus.fetch_valid = (state_q == RUN);
    pc              = pc_q;
    done            = (state_q == HALT);
  end

`ifdef INSTR_COUNT_EN
  // Counts non-stalled RUN cycles, halt fetch included, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (start) begin
      instr_count <= '0;
    end else if (state_q == RUN && !stall && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Covers the INSTR_COUNT_EN counter when that macro is defined.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch;
  logic [9:0]  pc;
  logic        done;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  logic [8:0]  mem [1024];
  int          checks;
  int          errors;

  instr_fetch_if #(.PC_W(10), .INSTR_W(9)) bus ();

  instr_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stall (stall),
    .bus   (bus.master),
    .pc    (pc),
    .done  (done)
`ifdef INSTR_COUNT_EN
    ,.instr_count (instr_count)
`endif
  );

  // Instruction memory model with combinational read, and the Control branch line
  always_comb begin
    bus.instr_rdata = mem[bus.instr_addr];
    bus.branch      = branch;
  end

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic s, input logic st, input logic br);
    start  = s;
    stall  = st;
    branch = br;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[0]  = 9'h000;
    mem[1]  = 9'h0A3;
    mem[2]  = 9'h1FF;
    mem[5]  = 9'h103;
    mem[40] = 9'h055;

    start  = 1'b0;
    stall  = 1'b0;
    branch = 1'b0;
    rst_n  = 1'b0;
    #3;
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_valid", 32'(bus.fetch_valid), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
`ifdef INSTR_COUNT_EN
    checkOutput("reset_count", 32'(instr_count), 32'd0);
`endif
    // A start pulse during reset is lost
    applyStimulus(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start_lost_valid", 32'(bus.fetch_valid), 32'd0);

    $display("[TB] basic program 0,1,2 then halt");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_pc0", 32'(pc), 32'd0);
    checkOutput("run_valid0", 32'(bus.fetch_valid), 32'd1);
    checkOutput("run_addr0", 32'(bus.instr_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run_pc1", 32'(pc), 32'd1);
    checkOutput("run_instr1", 32'(bus.instr), 32'h0A3);
    checkOutput("run_opcode1", 32'(bus.opcode), 32'h5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("run_pc2", 32'(pc), 32'd2);
    checkOutput("run_done2", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("halt_done", 32'(done), 32'd1);
    checkOutput("halt_pc", 32'(pc), 32'd2);
    checkOutput("halt_valid", 32'(bus.fetch_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("halt_stall_pc", 32'(pc), 32'd2);
    checkOutput("halt_stall_done", 32'(done), 32'd1);

    $display("[TB] taken branch at pc 5");
    mem[2] = 9'h000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_pc", 32'(pc), 32'd0);
    checkOutput("restart_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("br_pc5", 32'(pc), 32'd5);
    checkOutput("br_opcode5", 32'(bus.opcode), 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("br_target", 32'(pc), 32'd40);
    checkOutput("br_instr40", 32'(bus.instr), 32'h055);

    $display("[TB] not-taken branch and stall");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nobr_pc6", 32'(pc), 32'd6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc7", 32'(pc), 32'd7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("stall_pc7", 32'(pc), 32'd7);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_stall_pc8", 32'(pc), 32'd8);

    $display("[TB] halt word under stall, then with branch");
    mem[10] = 9'h1FF;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc10", 32'(pc), 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stall_halt_pc", 32'(pc), 32'd10);
    checkOutput("stall_halt_valid", 32'(bus.fetch_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("halt_br_pc", 32'(pc), 32'd10);
    checkOutput("halt_br_done", 32'(done), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("halt_start_pc", 32'(pc), 32'd0);
    checkOutput("halt_start_done", 32'(done), 32'd0);

    $display("[TB] start on halt word, then async reset");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc10_again", 32'(pc), 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_halt_pc", 32'(pc), 32'd0);
    checkOutput("start_halt_done", 32'(done), 32'd0);
    checkOutput("start_halt_valid", 32'(bus.fetch_valid), 32'd1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc9", 32'(pc), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pc", 32'(pc), 32'd0);
    checkOutput("async_rst_valid", 32'(bus.fetch_valid), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_idle", 32'(bus.fetch_valid), 32'd0);

    $display("[TB] wrap from last address");
    mem[3] = 9'h01F;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc3", 32'(pc), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pc_max", 32'(pc), 32'd1023);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pc_wrap", 32'(pc), 32'd0);

    $display("[TB] instruction count scenario");
    mem[5] = 9'h1FF;
    applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef INSTR_COUNT_EN
    checkOutput("count_cleared", 32'(instr_count), 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cnt_stall_pc", 32'(pc), 32'd2);
`ifdef INSTR_COUNT_EN
    checkOutput("count_stalled", 32'(instr_count), 32'd2);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("cnt_halt_done", 32'(done), 32'd1);
    checkOutput("cnt_halt_pc", 32'(pc), 32'd5);
`ifdef INSTR_COUNT_EN
    checkOutput("count_halt", 32'(instr_count), 32'd6);
`endif
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("cnt_restart_pc", 32'(pc), 32'd0);
`ifdef INSTR_COUNT_EN
    checkOutput("count_restart", 32'(instr_count), 32'd0);
`endif

    start = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
